// File: rtl/cruise_speed_unit_if.sv
// Command/result bundle between the cruise mode controller and the speed unit.
// Latency: n/a (wiring only); the master drives commands, the slave returns registered results.
// Backpressure: cmd_valid/cmd_ready handshake; cmd_ready drops while a ramp is running.
interface cruise_speed_unit_if #(
    parameter int W = 8
) ();
    logic         cmd_valid;  // command present
    logic         cmd_ready;  // unit can accept a command
    logic [2:0]   mode;       // 000 LOAD, 001 CMP, 010 INC, 011 DEC, 100 RAMP
    logic [W-1:0] c_speed;    // measured speed
    logic [W-1:0] d_speed;    // desired speed / ramp target
    logic         abort;      // terminate an active ramp
    logic [W-1:0] out_speed;  // registered speed result
    logic         out_valid;  // one-cycle pulse: out_speed updated
    logic         L;          // c_speed <  d_speed at last CMP
    logic         EQ;         // c_speed == d_speed at last CMP
    logic         G;          // c_speed >  d_speed at last CMP
    logic         sat;        // last result was clamped
    logic         busy;       // ramp in progress
    logic         ramp_done;  // one-cycle pulse: ramp reached target

    modport master (
        output cmd_valid, mode, c_speed, d_speed, abort,
        input  cmd_ready, out_speed, out_valid, L, EQ, G, sat, busy, ramp_done
    );

    modport slave (
        input  cmd_valid, mode, c_speed, d_speed, abort,
        output cmd_ready, out_speed, out_valid, L, EQ, G, sat, busy, ramp_done
    );
endinterface

// File: rtl/cruise_speed_unit.sv
// Cruise speed arithmetic: LOAD/CMP/INC/DEC with clamping, plus a slewed RAMP toward a target.
// Latency: 1 cycle from accept to out_valid; ramp steps land every RAMP_DIV cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; commands held during a ramp wait for its end.
// Ports: clock, reset (async, active-high), bus (slave modport of cruise_speed_unit_if).
module cruise_speed_unit #(
    parameter int W         = 8,
    parameter int STEP      = 5,
    parameter int MIN_SPEED = 0,
    parameter int MAX_SPEED = 255,
    parameter int RAMP_DIV  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cruise_speed_unit_if.slave    bus
);
    // Two guard bits so every "x < limit" test can be read off a borrow bit,
    // keeping the clamps free of constant comparisons when a limit sits at 0 or 2^W-1.
    localparam int XW = W + 2;
    localparam logic [XW-1:0] MIN_X     = XW'(MIN_SPEED);
    localparam logic [XW-1:0] MAX_X     = XW'(MAX_SPEED);
    localparam logic [XW-1:0] STEP_X    = XW'(STEP);
    localparam logic [XW-1:0] MINSTEP_X = XW'(MIN_SPEED + STEP);
    localparam logic [W-1:0]  MIN_W     = W'(MIN_SPEED);
    localparam logic [W-1:0]  MAX_W     = W'(MAX_SPEED);
    localparam logic [W-1:0]  STEP_W    = W'(STEP);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);

    localparam logic [2:0] MODE_LOAD = 3'b000;
    localparam logic [2:0] MODE_CMP  = 3'b001;
    localparam logic [2:0] MODE_INC  = 3'b010;
    localparam logic [2:0] MODE_DEC  = 3'b011;
    localparam logic [2:0] MODE_RAMP = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  out_speed_q, out_speed_d;
    logic [W-1:0]  target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          ramp_done_q, ramp_done_d;
    logic          l_q, l_d, eq_q, eq_d, g_q, g_d;
    logic          sat_q, sat_d;

    // ---------------- clamp / INC / DEC arithmetic ----------------
    logic [XW-1:0] d_x, lo_diff, hi_diff, inc_sum, inc_gap, dec_gap, dec_diff;
    logic          below_min, above_max, clamp_sat, inc_over, dec_floor;
    logic [W-1:0]  clamp_val, inc_val, dec_val;

    always_comb begin
        d_x       = {2'b00, bus.d_speed};
        lo_diff   = d_x - MIN_X;
        hi_diff   = MAX_X - d_x;
        below_min = lo_diff[XW-1];
        above_max = hi_diff[XW-1];
        clamp_sat = below_min | above_max;
        clamp_val = below_min ? MIN_W : (above_max ? MAX_W : bus.d_speed);

        // INC: carry-out of the W-bit sum lands in the guard bits and so also clamps.
        inc_sum   = d_x + STEP_X;
        inc_gap   = MAX_X - inc_sum;
        inc_over  = inc_gap[XW-1];
        inc_val   = inc_over ? MAX_W : inc_sum[W-1:0];

        // DEC: floor at MIN_SPEED instead of wrapping.
        dec_gap   = d_x - MINSTEP_X;
        dec_floor = dec_gap[XW-1];
        dec_diff  = d_x - STEP_X;
        dec_val   = dec_floor ? MIN_W : dec_diff[W-1:0];
    end

    // ---------------- ramp step toward target ----------------
    logic          ramp_up;
    logic [W-1:0]  ramp_dist, ramp_stp, ramp_next;

    always_comb begin
        ramp_up   = target_q > out_speed_q;
        ramp_dist = ramp_up ? (target_q - out_speed_q) : (out_speed_q - target_q);
        // The last step is shortened so the ramp never overshoots the target.
        ramp_stp  = (ramp_dist < STEP_W) ? ramp_dist : STEP_W;
        ramp_next = ramp_up ? (out_speed_q + ramp_stp) : (out_speed_q - ramp_stp);
    end

    // ---------------- next-state / outputs ----------------
    always_comb begin
        state_d     = state_q;
        out_speed_d = out_speed_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        ramp_done_d = 1'b0;
        l_d         = l_q;
        eq_d        = eq_q;
        g_d         = g_q;
        sat_d       = sat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (bus.mode)
                        MODE_LOAD: begin
                            out_speed_d = clamp_val;
                            sat_d       = clamp_sat;
                            out_valid_d = 1'b1;
                        end
                        MODE_CMP: begin
                            l_d         = bus.c_speed <  bus.d_speed;
                            eq_d        = bus.c_speed == bus.d_speed;
                            g_d         = bus.c_speed >  bus.d_speed;
                            out_valid_d = 1'b1;
                        end
                        MODE_INC: begin
                            out_speed_d = inc_val;
                            sat_d       = inc_over;
                            out_valid_d = 1'b1;
                        end
                        MODE_DEC: begin
                            out_speed_d = dec_val;
                            sat_d       = dec_floor;
                            out_valid_d = 1'b1;
                        end
                        MODE_RAMP: begin
                            target_d = clamp_val;
                            sat_d    = clamp_sat;
                            if (clamp_val == out_speed_q) begin
                                // Already there: report completion without entering RAMP.
                                out_valid_d = 1'b1;
                                ramp_done_d = 1'b1;
                            end else begin
                                state_d = ST_RAMP;
                                cnt_d   = '0;
                            end
                        end
                        default: ; // reserved modes are consumed silently
                    endcase
                end
            end
            ST_RAMP: begin
                if (cnt_q == CNT_LAST && ramp_next == target_q) begin
                    // Final step wins over a coincident abort.
                    cnt_d       = '0;
                    out_speed_d = ramp_next;
                    out_valid_d = 1'b1;
                    ramp_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    out_speed_d = ramp_next;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_speed_q <= MIN_W;
            target_q    <= MIN_W;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ramp_done_q <= 1'b0;
            l_q         <= 1'b0;
            eq_q        <= 1'b0;
            g_q         <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_speed_q <= out_speed_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ramp_done_q <= ramp_done_d;
            l_q         <= l_d;
            eq_q        <= eq_d;
            g_q         <= g_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_RAMP);
    assign bus.out_speed = out_speed_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ramp_done = ramp_done_q;
    assign bus.L         = l_q;
    assign bus.EQ        = eq_q;
    assign bus.G         = g_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_cruise_speed_unit.sv
// Bench for cruise_speed_unit: default instance plus a MIN_SPEED=20 instance.
// Latency: results checked one edge after accept; ramp steps checked at their scheduled edges.
// Backpressure: a command is held valid across a ramp to check it waits for IDLE.
module tb_cruise_speed_unit;
    localparam logic [2:0] M_LOAD = 3'b000;
    localparam logic [2:0] M_CMP  = 3'b001;
    localparam logic [2:0] M_INC  = 3'b010;
    localparam logic [2:0] M_DEC  = 3'b011;
    localparam logic [2:0] M_RAMP = 3'b100;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cruise_speed_unit_if #(.W(8)) bus   ();
    cruise_speed_unit_if #(.W(8)) bus20 ();

    cruise_speed_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    cruise_speed_unit #(.MIN_SPEED(20)) u_dut20 (
        .clock (clock),
        .reset (reset),
        .bus   (bus20)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] speed;
        logic       sat;
        logic       done;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] speed, input logic sat, input logic done);
        exp_t e;
        e.speed = speed;
        e.sat   = sat;
        e.done  = done;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] m, input logic [7:0] c, input logic [7:0] d);
        check("ready_before_cmd", bus.cmd_ready, 1);
        bus.mode      = m;
        bus.c_speed   = c;
        bus.d_speed   = d;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send20(input logic [2:0] m, input logic [7:0] d);
        bus20.mode      = m;
        bus20.c_speed   = 8'd0;
        bus20.d_speed   = d;
        bus20.cmd_valid = 1'b1;
        tick();
        bus20.cmd_valid = 1'b0;
    endtask

    // Scoreboard: every out_valid pulse of the default instance must match the next expected result.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.out_valid === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected: out_valid with out_speed %0d, nothing expected", bus.out_speed);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_speed", bus.out_speed, e.speed);
                check("sb_sat",   bus.sat,       e.sat);
                check("sb_done",  bus.ramp_done, e.done);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.mode = 3'b000; bus.c_speed = 8'd0; bus.d_speed = 8'd0; bus.abort = 1'b0;
        bus20.cmd_valid = 1'b0; bus20.mode = 3'b000; bus20.c_speed = 8'd0; bus20.d_speed = 8'd0; bus20.abort = 1'b0;
        reset = 1'b1;
        #12;
        // Reset values
        check("rst_out_speed", bus.out_speed, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_flags",     {bus.L, bus.EQ, bus.G}, 0);
        check("rst_sat",       bus.sat, 0);
        check("rst_ramp_done", bus.ramp_done, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst20_out_speed", bus20.out_speed, 20);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // DEC / LOAD / INC boundaries with MIN_SPEED = 20
        send20(M_DEC, 8'd23);
        check("dec20_23_speed", bus20.out_speed, 20);
        check("dec20_23_sat",   bus20.sat, 1);
        check("dec20_23_vld",   bus20.out_valid, 1);
        send20(M_DEC, 8'd25);
        check("dec20_25_speed", bus20.out_speed, 20);
        check("dec20_25_sat",   bus20.sat, 0);
        send20(M_LOAD, 8'd5);
        check("load20_5_speed", bus20.out_speed, 20);
        check("load20_5_sat",   bus20.sat, 1);
        send20(M_INC, 8'd250);
        check("inc20_250_speed", bus20.out_speed, 255);
        check("inc20_250_sat",   bus20.sat, 0);

        // INC saturation and normal INC
        push(8'd255, 1'b1, 1'b0);
        send(M_INC, 8'd0, 8'd253);
        check("inc253_speed", bus.out_speed, 255);
        check("inc253_sat",   bus.sat, 1);
        check("inc253_vld",   bus.out_valid, 1);
        tick();
        check("inc253_vld_pulse", bus.out_valid, 0);
        push(8'd105, 1'b0, 1'b0);
        send(M_INC, 8'd0, 8'd100);
        check("inc100_speed", bus.out_speed, 105);
        check("inc100_sat",   bus.sat, 0);

        // CMP and flag persistence
        push(8'd105, 1'b0, 1'b0);
        send(M_CMP, 8'd60, 8'd60);
        check("cmp_eq_flags", {bus.L, bus.EQ, bus.G}, 3'b010);
        check("cmp_eq_speed", bus.out_speed, 105);
        push(8'd105, 1'b0, 1'b0);
        send(M_CMP, 8'd61, 8'd60);
        check("cmp_gt_flags", {bus.L, bus.EQ, bus.G}, 3'b001);
        push(8'd15, 1'b0, 1'b0);
        send(M_INC, 8'd0, 8'd10);
        check("inc_after_cmp_speed", bus.out_speed, 15);
        check("flags_persist",       {bus.L, bus.EQ, bus.G}, 3'b001);

        // RAMP 50 -> 62 with a second command held valid throughout
        push(8'd50, 1'b0, 1'b0);
        send(M_LOAD, 8'd0, 8'd50);
        push(8'd55, 1'b0, 1'b0);
        push(8'd60, 1'b0, 1'b0);
        push(8'd62, 1'b0, 1'b1);
        send(M_RAMP, 8'd0, 8'd62);
        check("ramp_busy",      bus.busy, 1);
        check("ramp_ready_lo",  bus.cmd_ready, 0);
        check("ramp_accept_speed", bus.out_speed, 50);
        push(8'd77, 1'b0, 1'b0);
        bus.mode = M_LOAD; bus.d_speed = 8'd77; bus.cmd_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) check("ramp_step1", bus.out_speed, 55);
            if (k == 8) check("ramp_step2", bus.out_speed, 60);
            if (k < 12) begin
                check("ramp_ready_held", bus.cmd_ready, 0);
                check("ramp_no_done",    bus.ramp_done, 0);
            end
        end
        check("ramp_final_speed", bus.out_speed, 62);
        check("ramp_done_pulse",  bus.ramp_done, 1);
        check("ramp_end_busy",    bus.busy, 0);
        check("ramp_end_ready",   bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("held_cmd_speed", bus.out_speed, 77);
        check("held_cmd_vld",   bus.out_valid, 1);

        // RAMP 100 -> 80 aborted after the first step
        push(8'd100, 1'b0, 1'b0);
        send(M_LOAD, 8'd0, 8'd100);
        push(8'd95, 1'b0, 1'b0);
        send(M_RAMP, 8'd0, 8'd80);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) check("abort_step1", bus.out_speed, 95);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy",  bus.busy, 0);
        check("abort_ready", bus.cmd_ready, 1);
        check("abort_speed", bus.out_speed, 95);
        repeat (6) tick();
        check("abort_hold_speed", bus.out_speed, 95);
        check("abort_no_done",    bus.ramp_done, 0);

        // RAMP to current value completes immediately
        push(8'd95, 1'b0, 1'b1);
        send(M_RAMP, 8'd0, 8'd95);
        check("ramp_same_done", bus.ramp_done, 1);
        check("ramp_same_vld",  bus.out_valid, 1);
        check("ramp_same_busy", bus.busy, 0);
        check("ramp_same_ready", bus.cmd_ready, 1);
        tick();
        check("ramp_same_done_pulse", bus.ramp_done, 0);

        // Reserved mode (with a stray abort in IDLE) changes nothing
        bus.abort = 1'b1;
        send(3'b110, 8'd7, 8'd200);
        bus.abort = 1'b0;
        check("rsvd_vld",   bus.out_valid, 0);
        check("rsvd_speed", bus.out_speed, 95);
        check("rsvd_flags", {bus.L, bus.EQ, bus.G}, 3'b001);
        check("rsvd_sat",   bus.sat, 0);
        check("rsvd_ready", bus.cmd_ready, 1);

        // Reset mid-ramp: LOAD 100, RAMP 200, reset 6 cycles later
        push(8'd100, 1'b0, 1'b0);
        send(M_LOAD, 8'd0, 8'd100);
        push(8'd105, 1'b0, 1'b0);
        send(M_RAMP, 8'd0, 8'd200);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) check("rstramp_step1", bus.out_speed, 105);
        end
        check("rstramp_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("rstramp_speed", bus.out_speed, 0);
        check("rstramp_busy",  bus.busy, 0);
        check("rstramp_ready", bus.cmd_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("rstramp_ready_after", bus.cmd_ready, 1);
        check("rstramp_speed_after", bus.out_speed, 0);
        check("rstramp_vld_after",   bus.out_valid, 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
